// File: rtl/uart_pkg.sv
// Shared constants for the UART frame decoder: SOF marker, error codes and FSM state encoding.
package uart_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [1:0] WAIT_SOF = 2'd0;
  localparam logic [1:0] GET_LEN  = 2'd1;
  localparam logic [1:0] PAYLOAD  = 2'd2;
  localparam logic [1:0] GET_CHK  = 2'd3;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte-in / payload-and-status-out bundle of the UART frame decoder.
// master: byte source and result sink; slave: the decoder itself.
interface uart_frame_decoder_if;

  logic [7:0] din;
  logic       din_valid;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_first;
  logic       pl_last;
  logic       frame_done;
  logic       frame_ok;
  logic [1:0] err_code;

  modport master (
    output din, din_valid,
    input  pl_data, pl_valid, pl_first, pl_last, frame_done, frame_ok, err_code
  );

  modport slave (
    input  din, din_valid,
    output pl_data, pl_valid, pl_first, pl_last, frame_done, frame_ok, err_code
  );

endinterface

// File: rtl/uart_frame_decoder.sv
// Frame decoder: SOF(0xA5), LEN, LEN payload bytes, CHK (8-bit sum of LEN and payload).
// Payload bytes are streamed as they arrive; a status strobe closes every frame.
// Optional inter-byte timeout abort is built when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 8680
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_frame_decoder_if.slave  bus
);

  // Catch illegal configurations at elaboration time.
  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 1) begin : g_param_err
    $error("uart_frame_decoder: MAX_LEN must be 1..255 and TIMEOUT_CLKS nonzero");
  end

  logic [1:0] state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sum_q, sum_d;

  logic [7:0] pl_data_q, pl_data_d;
  logic       pl_valid_q, pl_valid_d;
  logic       pl_first_q, pl_first_d;
  logic       pl_last_q, pl_last_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_ok_q, frame_ok_d;
  logic [1:0] err_code_q, err_code_d;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_expired;

  // A byte arriving in the expiry cycle takes priority over the abort.
  assign tmo_expired = (state_q != WAIT_SOF) && !bus.din_valid &&
                       (tmo_q == TmoW'(TIMEOUT_CLKS));

  // Idle counter: cleared by every byte and whenever no frame is open.
  always_comb begin
    tmo_d = tmo_q + TmoW'(1);
    if (bus.din_valid || state_q == WAIT_SOF || tmo_expired) begin
      tmo_d = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  logic tmo_expired;
  assign tmo_expired = 1'b0;
`endif

  // Next-state, checksum, counter and output decode.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    pl_data_d    = pl_data_q;
    pl_valid_d   = 1'b0;
    pl_first_d   = pl_first_q;
    pl_last_d    = pl_last_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    err_code_d   = err_code_q;

    if (bus.din_valid) begin
      case (state_q)
        WAIT_SOF: begin
          if (bus.din == SOF_BYTE) state_d = GET_LEN;
        end
        GET_LEN: begin
          if (bus.din == 8'd0 || bus.din > 8'(MAX_LEN)) begin
            frame_done_d = 1'b1;
            frame_ok_d   = 1'b0;
            err_code_d   = ERR_LEN;
            state_d      = WAIT_SOF;
          end else begin
            len_d   = bus.din;
            sum_d   = bus.din;
            cnt_d   = 8'd0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          pl_valid_d = 1'b1;
          pl_data_d  = bus.din;
          pl_first_d = (cnt_q == 8'd0);
          pl_last_d  = (cnt_q + 8'd1 == len_q);
          sum_d      = sum_q + bus.din;
          cnt_d      = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) state_d = GET_CHK;
        end
        default: begin
          frame_done_d = 1'b1;
          frame_ok_d   = (bus.din == sum_q);
          err_code_d   = (bus.din == sum_q) ? ERR_NONE : ERR_CHK;
          state_d      = WAIT_SOF;
        end
      endcase
    end else if (tmo_expired) begin
      frame_done_d = 1'b1;
      frame_ok_d   = 1'b0;
      err_code_d   = ERR_TIMEOUT;
      state_d      = WAIT_SOF;
    end
  end

  // State and registered outputs; reset abandons any open frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_SOF;
      len_q        <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      pl_data_q    <= '0;
      pl_valid_q   <= 1'b0;
      pl_first_q   <= 1'b0;
      pl_last_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      pl_data_q    <= pl_data_d;
      pl_valid_q   <= pl_valid_d;
      pl_first_q   <= pl_first_d;
      pl_last_q    <= pl_last_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      err_code_q   <= err_code_d;
    end
  end

  assign bus.pl_data    = pl_data_q;
  assign bus.pl_valid   = pl_valid_q;
  assign bus.pl_first   = pl_first_q;
  assign bus.pl_last    = pl_last_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: expected payload/status events are queued as bytes are
// driven, observed events are collected at the falling edge and compared in order per scenario.
module tb_uart_frame_decoder;
  import uart_pkg::*;

  localparam int unsigned MAX_LEN      = 16;
  localparam int unsigned TIMEOUT_CLKS = 8680;
  localparam int          UART_GAP     = 434 * 10 - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_decoder_if bus ();

  uart_frame_decoder #(
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Event: {is_frame, data, first, last, ok, err}
  typedef logic [13:0] ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic ev_t pl_ev(input logic [7:0] d, input logic f, input logic l);
    return {1'b0, d, f, l, 1'b0, 2'b00};
  endfunction

  function automatic ev_t fd_ev(input logic ok, input logic [1:0] err);
    return {1'b1, 8'h00, 1'b0, 1'b0, ok, err};
  endfunction

  // Collect every strobe; a strobe held too long shows up as extra events.
  always @(negedge clk) begin
    if (bus.pl_valid) obs_q.push_back(pl_ev(bus.pl_data, bus.pl_first, bus.pl_last));
    if (bus.frame_done) obs_q.push_back(fd_ev(bus.frame_ok, bus.err_code));
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.din       = b;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset;
    bus.din = 8'h00;
    bus.din_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.pl_valid, bus.pl_first, bus.pl_last, bus.frame_done, bus.frame_ok} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {bus.pl_valid, bus.pl_first, bus.pl_last, bus.frame_done, bus.frame_ok});
    end
    n_checks++;
    if ({bus.pl_data, bus.err_code} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 000", {bus.pl_data, bus.err_code});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    obs_q.delete();
  endtask

  task automatic test_good_frame;
    logic [7:0] bytes [6];
    ev_t e, o;
    bytes = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    foreach (bytes[i]) send_byte(bytes[i], 2);
    exp_q.push_back(pl_ev(8'h11, 1, 0));
    exp_q.push_back(pl_ev(8'h22, 0, 0));
    exp_q.push_back(pl_ev(8'h33, 0, 1));
    exp_q.push_back(fd_ev(1, ERR_NONE));
    repeat (4) @(negedge clk); #1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL good_frame count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL good_frame event: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bad_chk;
    logic [7:0] bytes [6];
    ev_t e, o;
    bytes = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
    foreach (bytes[i]) send_byte(bytes[i], 1);
    exp_q.push_back(pl_ev(8'h11, 1, 0));
    exp_q.push_back(pl_ev(8'h22, 0, 0));
    exp_q.push_back(pl_ev(8'h33, 0, 1));
    exp_q.push_back(fd_ev(0, ERR_CHK));
    repeat (4) @(negedge clk); #1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL bad_chk count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL bad_chk event: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // LEN=0, LEN=MAX_LEN+1, then a full MAX_LEN frame and a minimal frame right after.
  task automatic test_len_bounds;
    ev_t e, o;
    logic [7:0] sum;
    send_byte(8'hA5, 0); send_byte(8'h00, 0);
    exp_q.push_back(fd_ev(0, ERR_LEN));
    send_byte(8'hA5, 0); send_byte(8'(MAX_LEN + 1), 0);
    exp_q.push_back(fd_ev(0, ERR_LEN));
    send_byte(8'hA5, 0); send_byte(8'(MAX_LEN), 0);
    sum = 8'(MAX_LEN);
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      send_byte(8'(i * 7 + 3), 0);
      sum = sum + 8'(i * 7 + 3);
      exp_q.push_back(pl_ev(8'(i * 7 + 3), i == 0, i == int'(MAX_LEN) - 1));
    end
    send_byte(sum, 0);
    exp_q.push_back(fd_ev(1, ERR_NONE));
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h07, 0); send_byte(8'h08, 0);
    exp_q.push_back(pl_ev(8'h07, 1, 1));
    exp_q.push_back(fd_ev(1, ERR_NONE));
    repeat (4) @(negedge clk); #1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL len_bounds count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL len_bounds event: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_garbage;
    logic [7:0] bytes [7];
    ev_t e, o;
    bytes = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hA5, 8'hA6};
    foreach (bytes[i]) send_byte(bytes[i], 3);
    exp_q.push_back(pl_ev(8'hA5, 1, 1));
    exp_q.push_back(fd_ev(1, ERR_NONE));
    repeat (4) @(negedge clk); #1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL garbage count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL garbage event: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall;
    ev_t e, o;
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h10, 0);
    exp_q.push_back(pl_ev(8'h10, 1, 0));
    repeat (TIMEOUT_CLKS + 20) @(negedge clk);
`ifdef UART_FRAME_TIMEOUT_EN
    exp_q.push_back(fd_ev(0, ERR_TIMEOUT));
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h07, 0); send_byte(8'h08, 0);
    exp_q.push_back(pl_ev(8'h07, 1, 1));
    exp_q.push_back(fd_ev(1, ERR_NONE));
`else
    // Without the timeout the frame stays open and completes normally.
    send_byte(8'h20, 0); send_byte(8'h32, 0);
    exp_q.push_back(pl_ev(8'h20, 0, 1));
    exp_q.push_back(fd_ev(1, ERR_NONE));
`endif
    repeat (4) @(negedge clk); #1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL stall count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL stall event: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    ev_t e, o;
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h10, 2);
    exp_q.push_back(pl_ev(8'h10, 1, 0));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h07, 1); send_byte(8'h08, 1);
    exp_q.push_back(pl_ev(8'h07, 1, 1));
    exp_q.push_back(fd_ev(1, ERR_NONE));
    repeat (4) @(negedge clk); #1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_mid_frame count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL reset_mid_frame event: got %h expected %h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [9];
    ev_t e, o;
    bytes = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05, 8'hA5, 8'h01, 8'hFF, 8'h00};
    foreach (bytes[i]) send_byte(bytes[i], UART_GAP);
    exp_q.push_back(pl_ev(8'h01, 1, 0));
    exp_q.push_back(pl_ev(8'h02, 0, 1));
    exp_q.push_back(fd_ev(1, ERR_NONE));
    exp_q.push_back(pl_ev(8'hFF, 1, 1));
    exp_q.push_back(fd_ev(1, ERR_NONE));
    // Same pair of frames with no idle cycles beyond the strobe gap.
    foreach (bytes[i]) send_byte(bytes[i], 0);
    exp_q.push_back(pl_ev(8'h01, 1, 0));
    exp_q.push_back(pl_ev(8'h02, 0, 1));
    exp_q.push_back(fd_ev(1, ERR_NONE));
    exp_q.push_back(pl_ev(8'hFF, 1, 1));
    exp_q.push_back(fd_ev(1, ERR_NONE));
    repeat (4) @(negedge clk); #1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL back_to_back count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL back_to_back event: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_bounds();
    test_garbage();
    test_stall();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
